// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg
// Shared types, field widths and small arithmetic helpers for the
// timekeeper/alarm core and its per-alarm channel.
//   alarm_state_t : per-alarm FSM state (OFF, ARMED, RINGING, SNOOZED)
//   SEC_W/MIN_W/HR_W : widths of the seconds/minutes/hours fields
//   CNT_W            : width of the ring-timeout and snooze counters
//   hour_max()       : largest hour value for the selected hour range
//   inc_mod60()      : +1 with wrap 59 -> 0
//   inc_hour()       : +1 with wrap at the supplied maximum hour
package timekeeper_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        AL_OFF     = 2'd0,
        AL_ARMED   = 2'd1,
        AL_RINGING = 2'd2,
        AL_SNOOZED = 2'd3
    } alarm_state_t;

    function automatic logic [HR_W-1:0] hour_max(input bit hour_24);
        return hour_24 ? 5'd23 : 5'd11;
    endfunction

    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [HR_W-1:0] inc_hour(input logic [HR_W-1:0] v,
                                                  input logic [HR_W-1:0] hmax);
        return (v >= hmax) ? '0 : v + 5'd1;
    endfunction

endpackage

// File: rtl/timekeeper_alarm_core_alarm_channel.sv
// alarm_channel
// One alarm: its programmed hour/minute, a rising-edge match detector
// against the running wall time, the OFF/ARMED/RINGING/SNOOZED state
// machine and its ring-timeout and snooze counters.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   seconds_i/minutes_i/hours_i current (registered) wall time
//   minute_roll_i              one-cycle pulse when seconds wrap 59 -> 0
//   sel_hit_i                  this channel is the one addressed by al_sel
//   al_adj_min_i/al_adj_hr_i   alarm time set pulses (qualified by sel_hit_i)
//   al_toggle_i                arm/disarm pulse (qualified by sel_hit_i)
//   snooze_i/dismiss_i         global pulses
//   al_minutes_o/al_hours_o    programmed alarm time
//   enabled_o                  state is not OFF
//   ringing_o                  state is RINGING
module alarm_channel
    import timekeeper_pkg::*;
#(
    parameter int HOUR_24          = 0,
    parameter int ALARM_STEP_MIN   = 10,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEC_W-1:0] seconds_i,
    input  logic [MIN_W-1:0] minutes_i,
    input  logic [HR_W-1:0]  hours_i,
    input  logic             minute_roll_i,
    input  logic             sel_hit_i,
    input  logic             al_adj_min_i,
    input  logic             al_adj_hr_i,
    input  logic             al_toggle_i,
    input  logic             snooze_i,
    input  logic             dismiss_i,
    output logic [MIN_W-1:0] al_minutes_o,
    output logic [HR_W-1:0]  al_hours_o,
    output logic             enabled_o,
    output logic             ringing_o
);

    localparam logic [HR_W-1:0]  HMAX       = hour_max(HOUR_24 != 0);
    localparam logic [MIN_W:0]   STEP_MOD   = (MIN_W+1)'(ALARM_STEP_MIN % 60);
    localparam logic [CNT_W-1:0] RING_LOAD  = CNT_W'(RING_TIMEOUT_MIN);
    localparam logic [CNT_W-1:0] SNZ_LOAD   = CNT_W'(SNOOZE_MIN);

    logic [MIN_W-1:0] al_min_q, al_min_d;
    logic [HR_W-1:0]  al_hr_q,  al_hr_d;
    logic             match_q;
    logic             match;
    logic             match_rise;
    alarm_state_t     state_q, state_d;
    logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [CNT_W-1:0] snz_cnt_q,  snz_cnt_d;
    logic             enabled_q, ringing_q;
    logic [MIN_W:0]   al_min_sum;
    logic             toggle;

    assign toggle     = al_toggle_i & sel_hit_i;
    assign match      = (hours_i == al_hr_q) && (minutes_i == al_min_q) && (seconds_i == '0);
    // Edge detect so a match held for a whole second (or reached by the set
    // buttons) fires exactly once.
    assign match_rise = match & ~match_q;
    assign al_min_sum = {1'b0, al_min_q} + STEP_MOD;

    // Alarm time registers: the step wraps within the hour and never carries.
    always_comb begin
        al_min_d = al_min_q;
        al_hr_d  = al_hr_q;
        if (sel_hit_i && al_adj_min_i) begin
            al_min_d = (al_min_sum >= 7'd60) ? MIN_W'(al_min_sum - 7'd60)
                                             : al_min_sum[MIN_W-1:0];
        end
        if (sel_hit_i && al_adj_hr_i) begin
            al_hr_d = inc_hour(al_hr_q, HMAX);
        end
    end

    // Next-state logic; branch order encodes toggle > dismiss > snooze > timeout/match.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        unique case (state_q)
            AL_OFF: begin
                if (toggle) state_d = AL_ARMED;
            end
            AL_ARMED: begin
                if (toggle) begin
                    state_d = AL_OFF;
                end else if (dismiss_i || snooze_i) begin
                    state_d = AL_ARMED;
                end else if (match_rise) begin
                    state_d    = AL_RINGING;
                    ring_cnt_d = RING_LOAD;
                end
            end
            AL_RINGING: begin
                if (toggle) begin
                    state_d = AL_OFF;
                end else if (dismiss_i) begin
                    state_d = AL_ARMED;
                end else if (snooze_i) begin
                    state_d   = AL_SNOOZED;
                    snz_cnt_d = SNZ_LOAD;
                end else if (minute_roll_i) begin
                    // Auto-dismiss once the last unattended minute elapses.
                    if (ring_cnt_q <= 4'd1) begin
                        ring_cnt_d = '0;
                        state_d    = AL_ARMED;
                    end else begin
                        ring_cnt_d = ring_cnt_q - 4'd1;
                    end
                end
            end
            AL_SNOOZED: begin
                if (toggle) begin
                    state_d = AL_OFF;
                end else if (dismiss_i) begin
                    state_d = AL_ARMED;
                end else if (minute_roll_i) begin
                    if (snz_cnt_q <= 4'd1) begin
                        snz_cnt_d  = '0;
                        state_d    = AL_RINGING;
                        ring_cnt_d = RING_LOAD;
                    end else begin
                        snz_cnt_d = snz_cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = AL_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            al_min_q   <= '0;
            al_hr_q    <= '0;
            match_q    <= 1'b0;
            state_q    <= AL_OFF;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            enabled_q  <= 1'b0;
            ringing_q  <= 1'b0;
        end else begin
            al_min_q   <= al_min_d;
            al_hr_q    <= al_hr_d;
            match_q    <= match;
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            enabled_q  <= (state_d != AL_OFF);
            ringing_q  <= (state_d == AL_RINGING);
        end
    end

    assign al_minutes_o = al_min_q;
    assign al_hours_o   = al_hr_q;
    assign enabled_o    = enabled_q;
    assign ringing_o    = ringing_q;

endmodule

// File: rtl/timekeeper_alarm_core.sv
// timekeeper_alarm_core
// Wall-clock timekeeper (seconds/minutes/hours with carries, 12 h or 24 h
// range) plus NUM_ALARMS independent alarm channels and a gated buzzer.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   sec_tick_i, tone_tick_i         1 Hz pulse, 2x tone-frequency pulse
//   adj_sec_i/adj_min_i/adj_hr_i    time set pulses
//   al_sel_i                        alarm addressed by the al_* pulses
//   al_adj_min_i/al_adj_hr_i        alarm time set pulses
//   al_toggle_i                     arm/disarm the selected alarm
//   snooze_i, dismiss_i             global alarm pulses
//   seconds_o/minutes_o/hours_o     wall time
//   al_minutes_o/al_hours_o         packed alarm times, alarm 0 in the LSBs
//   al_enabled_o, al_ringing_o      per-alarm status bits
//   buzzer_out_o                    gated tone, 1 s on / 1 s off while ringing
module timekeeper_alarm_core
    import timekeeper_pkg::*;
#(
    parameter int NUM_ALARMS       = 2,
    parameter int HOUR_24          = 0,
    parameter int ALARM_STEP_MIN   = 10,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sec_tick_i,
    input  logic                        tone_tick_i,
    input  logic                        adj_sec_i,
    input  logic                        adj_min_i,
    input  logic                        adj_hr_i,
    input  logic [1:0]                  al_sel_i,
    input  logic                        al_adj_min_i,
    input  logic                        al_adj_hr_i,
    input  logic                        al_toggle_i,
    input  logic                        snooze_i,
    input  logic                        dismiss_i,
    output logic [SEC_W-1:0]            seconds_o,
    output logic [MIN_W-1:0]            minutes_o,
    output logic [HR_W-1:0]             hours_o,
    output logic [MIN_W*NUM_ALARMS-1:0] al_minutes_o,
    output logic [HR_W*NUM_ALARMS-1:0]  al_hours_o,
    output logic [NUM_ALARMS-1:0]       al_enabled_o,
    output logic [NUM_ALARMS-1:0]       al_ringing_o,
    output logic                        buzzer_out_o
);

    localparam logic [HR_W-1:0] HMAX = hour_max(HOUR_24 != 0);

    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [HR_W-1:0]  hr_q,  hr_d;
    logic             sec_wrap;
    logic             min_wrap;
    logic             minute_roll;
    logic             any_ring;
    logic             beat_q, beat_d;
    logic             tone_q;
    logic             buzzer_q;

    // adj_sec swallows the tick, so it also kills the carry out of seconds.
    // An adjust on a field overrides an incoming carry into that field.
    assign sec_wrap    = sec_tick_i && !adj_sec_i && (sec_q == 6'd59);
    assign min_wrap    = sec_wrap && !adj_min_i && (min_q == 6'd59);
    assign minute_roll = sec_wrap;

    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        if (adj_sec_i) begin
            sec_d = '0;
        end else if (sec_tick_i) begin
            sec_d = inc_mod60(sec_q);
        end
        if (adj_min_i || sec_wrap) begin
            min_d = inc_mod60(min_q);
        end
        if (adj_hr_i || min_wrap) begin
            hr_d = inc_hour(hr_q, HMAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q <= '0;
            min_q <= '0;
            hr_q  <= '0;
        end else begin
            sec_q <= sec_d;
            min_q <= min_d;
            hr_q  <= hr_d;
        end
    end

    assign seconds_o = sec_q;
    assign minutes_o = min_q;
    assign hours_o   = hr_q;

    generate
        for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
            logic [MIN_W-1:0] ch_min;
            logic [HR_W-1:0]  ch_hr;
            logic             ch_en;
            logic             ch_ring;
            logic             sel_hit;

            // al_sel values at or above NUM_ALARMS match no channel.
            assign sel_hit = (al_sel_i == 2'(gi));

            alarm_channel #(
                .HOUR_24          (HOUR_24),
                .ALARM_STEP_MIN   (ALARM_STEP_MIN),
                .SNOOZE_MIN       (SNOOZE_MIN),
                .RING_TIMEOUT_MIN (RING_TIMEOUT_MIN)
            ) u_channel (
                .clk           (clk),
                .reset         (reset),
                .seconds_i     (sec_q),
                .minutes_i     (min_q),
                .hours_i       (hr_q),
                .minute_roll_i (minute_roll),
                .sel_hit_i     (sel_hit),
                .al_adj_min_i  (al_adj_min_i),
                .al_adj_hr_i   (al_adj_hr_i),
                .al_toggle_i   (al_toggle_i),
                .snooze_i      (snooze_i),
                .dismiss_i     (dismiss_i),
                .al_minutes_o  (ch_min),
                .al_hours_o    (ch_hr),
                .enabled_o     (ch_en),
                .ringing_o     (ch_ring)
            );

            assign al_minutes_o[gi*MIN_W +: MIN_W] = ch_min;
            assign al_hours_o[gi*HR_W +: HR_W]     = ch_hr;
            assign al_enabled_o[gi]                = ch_en;
            assign al_ringing_o[gi]                = ch_ring;
        end
    endgenerate

    // Buzzer: beat gives the 1 s on / 1 s off cadence, tone the audio square
    // wave; beat restarts from 0 each time ringing begins.
    assign any_ring = |al_ringing_o;

    always_comb begin
        beat_d = beat_q;
        if (!any_ring) begin
            beat_d = 1'b0;
        end else if (sec_tick_i) begin
            beat_d = ~beat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q   <= 1'b0;
            tone_q   <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            beat_q   <= beat_d;
            tone_q   <= tone_q ^ tone_tick_i;
            buzzer_q <= any_ring & beat_q & tone_q;
        end
    end

    assign buzzer_out_o = buzzer_q;

endmodule
